// File: rtl/branch_cond_reg_pkg.sv
// +----------------------------------------------------------------------+
// | branch_cond_pkg : branch-condition select encodings (IR_C2)          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package branch_cond_pkg;

  typedef enum logic [1:0] {
    COND_ZR = 2'b00,
    COND_NZ = 2'b01,
    COND_PL = 2'b10,
    COND_MI = 2'b11
  } cond_e;

endpackage

`default_nettype wire

// File: rtl/branch_cond_reg_if.sv
// +----------------------------------------------------------------------+
// | branch_cond_reg_if : evaluate request / result handshake bundle      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface branch_cond_reg_if #(
  parameter int DATA_W = 32
);

  logic [DATA_W-1:0] busContents;
  logic [1:0]        IR_C2;
  logic              CONin;
  logic              con_ack;
  logic              q;
  logic              q_valid;

  modport master (
    output busContents,
    output IR_C2,
    output CONin,
    output con_ack,
    input  q,
    input  q_valid
  );

  modport slave (
    input  busContents,
    input  IR_C2,
    input  CONin,
    input  con_ack,
    output q,
    output q_valid
  );

endinterface

`default_nettype wire

// File: rtl/branch_cond_reg_cond_eval.sv
// +----------------------------------------------------------------------+
// | cond_eval : combinational zero / nonzero / sign condition decode     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module cond_eval
  import branch_cond_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] operand,
  input  logic [1:0]        select,
  output logic              result
);

  always_comb begin
    result = 1'b0;
    case (cond_e'(select))
      COND_ZR: result = (operand == '0);
      COND_NZ: result = (operand != '0);
      COND_PL: result = ~operand[DATA_W-1];
      COND_MI: result =  operand[DATA_W-1];
      default: result = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/branch_cond_reg.sv
// +----------------------------------------------------------------------+
// | branch_cond_reg : registered branch condition with handshake + stats |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module branch_cond_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int PIPE   = 0
) (
  input  logic              clock,
  input  logic              clear,
  branch_cond_reg_if.slave  bus,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  eval_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  if (PIPE != 0 && PIPE != 1) begin : g_bad_pipe
    $error("branch_cond_reg: PIPE must be 0 or 1");
  end
  if (DATA_W < 2 || DATA_W > 64) begin : g_bad_width
    $error("branch_cond_reg: DATA_W must be in 2..64");
  end

  logic              ev_valid;
  logic [1:0]        ev_sel;
  logic [DATA_W-1:0] ev_bus;
  logic              ev_res;
  logic              q_state;
  logic              valid_state;

  if (PIPE == 1) begin : g_pipe
    logic              stg_valid;
    logic [1:0]        stg_sel;
    logic [DATA_W-1:0] stg_bus;

    // Stage valid is cleared by reset so an in-flight evaluation never lands.
    always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
        stg_valid <= 1'b0;
        stg_sel   <= 2'b00;
        stg_bus   <= '0;
      end else begin
        stg_valid <= bus.CONin;
        if (bus.CONin) begin
          stg_sel <= bus.IR_C2;
          stg_bus <= bus.busContents;
        end
      end
    end

    assign ev_valid = stg_valid;
    assign ev_sel   = stg_sel;
    assign ev_bus   = stg_bus;
  end else begin : g_direct
    assign ev_valid = bus.CONin;
    assign ev_sel   = bus.IR_C2;
    assign ev_bus   = bus.busContents;
  end

  cond_eval #(.DATA_W(DATA_W)) u_cond_eval (
    .operand (ev_bus),
    .select  (ev_sel),
    .result  (ev_res)
  );

  // A landing result beats a same-cycle acknowledge.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      q_state     <= 1'b0;
      valid_state <= 1'b0;
    end else if (ev_valid) begin
      q_state     <= ev_res;
      valid_state <= 1'b1;
    end else if (bus.con_ack) begin
      valid_state <= 1'b0;
    end
  end

  assign bus.q       = q_state;
  assign bus.q_valid = valid_state;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      eval_cnt  <= '0;
      taken_cnt <= '0;
    end else if (cnt_clr) begin
      eval_cnt  <= '0;
      taken_cnt <= '0;
    end else begin
      if (ev_valid && (eval_cnt != '1)) begin
        eval_cnt <= eval_cnt + CNT_ONE;
      end
      if (ev_valid && ev_res && (taken_cnt != '1)) begin
        taken_cnt <= taken_cnt + CNT_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_cond_reg.sv
// +----------------------------------------------------------------------+
// | tb_branch_cond_reg : scoreboard bench, PIPE=0/CNT_W=3 and PIPE=1     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_branch_cond_reg;

  localparam int DW = 32;

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  branch_cond_reg_if #(.DATA_W(DW)) if0 ();
  branch_cond_reg_if #(.DATA_W(DW)) if1 ();

  logic          cnt_clr0, cnt_clr1;
  logic [2:0]    ec0, tc0;
  logic [15:0]   ec1, tc1;

  branch_cond_reg #(.DATA_W(DW), .CNT_W(3), .PIPE(0)) dut0 (
    .clock (clock), .clear (clear), .bus (if0),
    .cnt_clr (cnt_clr0), .eval_cnt (ec0), .taken_cnt (tc0)
  );

  branch_cond_reg #(.DATA_W(DW), .CNT_W(16), .PIPE(1)) dut1 (
    .clock (clock), .clear (clear), .bus (if1),
    .cnt_clr (cnt_clr1), .eval_cnt (ec1), .taken_cnt (tc1)
  );

  // stimulus variables, one slot per DUT
  logic          con  [2];
  logic [1:0]    sel  [2];
  logic [DW-1:0] bdat [2];
  logic          ack  [2];
  logic          cclr [2];

  assign if0.CONin = con[0];  assign if0.IR_C2 = sel[0];
  assign if0.busContents = bdat[0];  assign if0.con_ack = ack[0];
  assign if1.CONin = con[1];  assign if1.IR_C2 = sel[1];
  assign if1.busContents = bdat[1];  assign if1.con_ack = ack[1];
  assign cnt_clr0 = cclr[0];
  assign cnt_clr1 = cclr[1];

  // reference model
  typedef struct { int d; int land; bit r; } pend_t;
  typedef struct { int d; int q; int v; int e; int t; string tag; } snap_t;

  pend_t pq[$];
  snap_t sb[$];
  int    m_q [2], m_v [2], m_e [2], m_t [2];
  int    maxc [2] = '{7, 65535};
  int    pipe [2] = '{0, 1};
  int    edge_n = 0;
  string cur_tag = "init";

  int total = 0;
  int bad   = 0;

  function automatic bit ref_cond(logic [1:0] s, logic [DW-1:0] b);
    case (s)
      2'd0:    return b == 0;
      2'd1:    return b != 0;
      2'd2:    return $signed(b) >= 0;
      default: return $signed(b) < 0;
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      con[d]  = 1'b0;
      ack[d]  = 1'b0;
      cclr[d] = 1'b0;
      sel[d]  = 2'($urandom_range(0, 3));
      bdat[d] = $urandom;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_q[d] = 0; m_v[d] = 0; m_e[d] = 0; m_t[d] = 0;
    end
    pq.delete();
  endtask

  // one clock: model the edge, push expectations, then return inputs to idle
  task automatic tick();
    @(posedge clock);
    edge_n++;
    for (int d = 0; d < 2; d++)
      if (con[d]) pq.push_back('{d, edge_n + pipe[d], ref_cond(sel[d], bdat[d])});
    for (int d = 0; d < 2; d++) begin
      bit land = 1'b0;
      bit r    = 1'b0;
      for (int i = 0; i < pq.size(); i++) begin
        if (pq[i].d == d && pq[i].land == edge_n) begin
          land = 1'b1;
          r    = pq[i].r;
          pq.delete(i);
          break;
        end
      end
      if (land) begin
        m_q[d] = int'(r);
        m_v[d] = 1;
      end else if (ack[d]) begin
        m_v[d] = 0;
      end
      if (cclr[d]) begin
        m_e[d] = 0;
        m_t[d] = 0;
      end else if (land) begin
        if (m_e[d] < maxc[d]) m_e[d]++;
        if (r && m_t[d] < maxc[d]) m_t[d]++;
      end
      sb.push_back('{d, m_q[d], m_v[d], m_e[d], m_t[d], cur_tag});
    end
    @(negedge clock);
    #1;
    idle_inputs();
  endtask

  task automatic check_idle_state(string name);
    chk({name, "_q0"},  int'(if0.q), 0);
    chk({name, "_v0"},  int'(if0.q_valid), 0);
    chk({name, "_e0"},  int'(ec0), 0);
    chk({name, "_t0"},  int'(tc0), 0);
    chk({name, "_q1"},  int'(if1.q), 0);
    chk({name, "_v1"},  int'(if1.q_valid), 0);
    chk({name, "_e1"},  int'(ec1), 0);
    chk({name, "_t1"},  int'(tc1), 0);
  endtask

  // asynchronous clear pulse placed between two rising edges
  task automatic pulse_clear();
    clear = 1'b0;
    model_reset();
    #1;
    check_idle_state("async_clear");
    #1;
    clear = 1'b1;
  endtask

  // monitor: compare every expected snapshot against the DUT outputs
  initial begin
    snap_t s;
    forever begin
      @(negedge clock);
      while (sb.size() > 0) begin
        s = sb.pop_front();
        if (s.d == 0) begin
          chk({s.tag, "_q0"}, int'(if0.q), s.q);
          chk({s.tag, "_v0"}, int'(if0.q_valid), s.v);
          chk({s.tag, "_e0"}, int'(ec0), s.e);
          chk({s.tag, "_t0"}, int'(tc0), s.t);
        end else begin
          chk({s.tag, "_q1"}, int'(if1.q), s.q);
          chk({s.tag, "_v1"}, int'(if1.q_valid), s.v);
          chk({s.tag, "_e1"}, int'(ec1), s.e);
          chk({s.tag, "_t1"}, int'(tc1), s.t);
        end
      end
    end
  end

  initial begin
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    check_idle_state("reset");
    clear = 1'b1;

    // PIPE=0 zero test, first edge after reset release
    cur_tag = "zr_bus0";
    con[0] = 1; sel[0] = 2'b00; bdat[0] = 0;
    tick();
    chk("zr_bus0_q_direct", int'(if0.q), 1);
    cur_tag = "zr_bus5";
    con[0] = 1; sel[0] = 2'b00; bdat[0] = 5;
    tick();
    chk("zr_bus5_q_direct", int'(if0.q), 0);

    // PIPE=1 three back-to-back evaluations
    cur_tag = "pipe_seq";
    cclr[1] = 1;
    con[1] = 1; sel[1] = 2'b11; bdat[1] = 32'h8000_0000;
    tick();
    con[1] = 1; sel[1] = 2'b10; bdat[1] = 32'h8000_0000;
    tick();
    chk("pipe_seq_q_e2", int'(if1.q), 1);
    con[1] = 1; sel[1] = 2'b01; bdat[1] = 7;
    tick();
    chk("pipe_seq_q_e3", int'(if1.q), 0);
    tick();
    chk("pipe_seq_q_e4", int'(if1.q), 1);
    chk("pipe_seq_eval", int'(ec1), 3);
    chk("pipe_seq_taken", int'(tc1), 2);

    // acknowledge colliding with a landing result of 0, then ack alone
    cur_tag = "ack_collide";
    con[0] = 1; sel[0] = 2'b01; bdat[0] = 0; ack[0] = 1;
    tick();
    chk("ack_collide_v", int'(if0.q_valid), 1);
    cur_tag = "ack_alone";
    ack[0] = 1;
    tick();
    chk("ack_alone_v", int'(if0.q_valid), 0);
    cur_tag = "ack_idle";
    ack[0] = 1;
    tick();

    // CNT_W=3 saturation, then clear racing a landing
    cur_tag = "sat";
    cclr[0] = 1;
    tick();
    for (int i = 0; i < 9; i++) begin
      con[0] = 1; sel[0] = 2'b00; bdat[0] = 0;
      tick();
    end
    chk("sat_eval", int'(ec0), 7);
    chk("sat_taken", int'(tc0), 7);
    cur_tag = "clr_vs_land";
    cclr[0] = 1; con[0] = 1; sel[0] = 2'b00; bdat[0] = 0;
    tick();
    chk("clr_vs_land_eval", int'(ec0), 0);
    chk("clr_vs_land_taken", int'(tc0), 0);

    // in-flight evaluation discarded by clear
    cur_tag = "flight_kill";
    con[1] = 1; sel[1] = 2'b00; bdat[1] = 0;
    tick();
    pulse_clear();
    tick();
    chk("flight_kill_v", int'(if1.q_valid), 0);
    chk("flight_kill_e", int'(ec1), 0);

    // randomized traffic on both instances
    cur_tag = "rand";
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        con[d]  = ($urandom_range(0, 9) < 7);
        sel[d]  = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0:       bdat[d] = 0;
          1:       bdat[d] = 32'h8000_0000;
          2:       bdat[d] = 32'hFFFF_FFFF;
          default: bdat[d] = $urandom;
        endcase
        ack[d]  = ($urandom_range(0, 9) < 3);
        cclr[d] = ($urandom_range(0, 99) < 3);
      end
      tick();
      if ($urandom_range(0, 99) == 0) pulse_clear();
    end

    @(negedge clock);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
